geofence_feeder: RTL and testbench
==================================

Name: geofence_feeder

Overview:
- Upstream stage of the geofence evaluator.
- Accepts coordinate beats from the host over a valid/ready handshake and buffers them into two ping-pong banks of 7 points each. A group is point 0 (receiver) followed by points 1..6 (fence).
- Holds the evaluator in reset until a complete group is buffered, streams the group on 7 consecutive cycles, then waits for the evaluator's valid pulse.
- Captures each verdict and returns it to the host with a group tag.

Parameters:
- CW, 10: coordinate width in bits.
- PTS, 7: points per group; fixed by the evaluator.
- TW, 8: result tag width in bits.

Ports:
- clk, input, 1: clock; all logic is on the rising edge.
- reset_n, input, 1: asynchronous active-low reset.
- in_valid, input, 1: host beat valid.
- in_ready, output, 1: feeder can accept a beat.
- in_x, input, CW: host X coordinate.
- in_y, input, CW: host Y coordinate.
- in_last, input, 1: marks the final (7th) beat of a group.
- gf_reset, output, 1: active-high reset driven to the evaluator.
- X, output, CW: coordinate X to the evaluator.
- Y, output, CW: coordinate Y to the evaluator.
- gf_valid, input, 1: evaluator result strobe.
- gf_is_inside, input, 1: evaluator verdict.
- res_valid, output, 1: one-cycle result pulse to the host.
- res_inside, output, 1: registered verdict.
- res_tag, output, TW: sequence number of the group.
- frame_err, output, 1: one-cycle pulse when a group is discarded.

Behaviour:
- Reset values: gf_reset=1, X=Y=0, res_valid=0, res_inside=0, res_tag=0, frame_err=0, both banks empty, write and read pointers at bank 0, tag counter 0.
- While reset_n is low, in_ready is forced to 0.
- Reset asserted mid-stream or mid-load discards all buffered data.
- Input side:
  - A beat is accepted when in_valid and in_ready are both high.
  - in_ready is high iff the write bank is not full.
  - Beat index 0..6 addresses the write bank.
  - in_last on index 6: the bank is marked full and the write pointer toggles.
  - in_last on an index below 6: the partial group is discarded, the index returns to 0, and frame_err pulses.
  - Index 6 accepted without in_last: the group is discarded, frame_err pulses, and the feeder enters RESYNC. In RESYNC, beats are accepted and dropped until a beat with in_last is dropped; the index then returns to 0.
- Stream-side FSM states: IDLE, STREAM, WAIT.
  - IDLE: gf_reset=1. When the read bank is full, at clock edge E0 register gf_reset=0, X/Y=point 0, count=0, and go to STREAM.
  - STREAM: at each edge Ek (k=1..6), X/Y=point k. At E7 the read bank is freed, the read pointer toggles, and the state goes to WAIT. The evaluator samples point k at edge E(k+1). After E7, X/Y hold point 6.
  - WAIT: on an edge with gf_valid=1, register res_valid=1, res_inside=gf_is_inside, res_tag=tag counter, and increment the tag counter (wraps at 2^TW).
    - If the new read bank is full on that same edge, load X/Y=point 0 of that bank, keep gf_reset=0, and go to STREAM. The evaluator re-enters its read phase on the following cycle.
    - Otherwise set gf_reset=1 and go to IDLE.
  - gf_valid outside WAIT is ignored.
- Simultaneous events: a bank freed at E7 on the same edge the host completes the other bank is legal. Both banks full drops in_ready. Loading and streaming always target different banks.
- Latency:
  - First result: 7 stream cycles after gf_reset falls, plus evaluator time.
  - Back-to-back groups: zero idle cycles between gf_valid and the next point 0.
  - res_valid comes 1 cycle after gf_valid.

Test Plan:
- Single group: beats (5,5),(0,0),(10,0),(12,6),(10,10),(0,10),(-) filled with (2,8), in_last on the 7th; bench model returns gf_is_inside=1 -> gf_reset falls, X/Y show those 7 points on consecutive cycles, then res_valid=1, res_inside=1, res_tag=0.
- Back-to-back: 3 groups pushed without gaps -> in_ready drops only while both banks are full, point 0 of group 2 appears on the cycle gf_valid is sampled, gf_reset stays 0 throughout, res_tag=0,1,2.
- Framing: in_last on the 4th beat -> frame_err pulse, no stream starts. A following good group is streamed and tagged 0.
- Missing in_last: 9 beats with in_last only on the 9th -> one frame_err at beat 7, beats 8-9 dropped, no result. The next group streams normally.
- Reset mid-stream: reset_n low at stream cycle 3 -> gf_reset=1 immediately, res_valid=0, banks empty, in_ready=0 during reset and 1 after.
- Tag wrap: 257 groups with TW=8 -> the last res_tag equals 0.

Source files
------------

// File: rtl/geofence_feeder.sv
// geofence_feeder: buffers host coordinate groups into two ping-pong banks,
// streams each complete group to the geofence evaluator and returns tagged verdicts.
module geofence_feeder #(
    parameter int CW  = 10,
    parameter int PTS = 7,
    parameter int TW  = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [CW-1:0] in_x,
    input  logic [CW-1:0] in_y,
    input  logic          in_last,
    output logic          gf_reset,
    output logic [CW-1:0] X,
    output logic [CW-1:0] Y,
    input  logic          gf_valid,
    input  logic          gf_is_inside,
    output logic          res_valid,
    output logic          res_inside,
    output logic [TW-1:0] res_tag,
    output logic          frame_err
);
    localparam int IW = $clog2(PTS);
    localparam logic [IW-1:0] LAST_IDX = IW'(PTS - 1);

    typedef enum logic [1:0] {IDLE, STREAM, WAIT} state_t;

    state_t state, state_nx;
    logic [CW-1:0] bank_x [2][PTS];
    logic [CW-1:0] bank_y [2][PTS];
    logic [1:0] full;
    logic wr_ptr, rd_ptr, resync;
    logic [IW-1:0] wr_idx, cnt;
    logic [TW-1:0] tag;
    logic accept, wr_done, wr_bad;
    logic start, advance, release_bank, capture;

    assign in_ready = reset_n && !full[wr_ptr];
    assign accept   = in_valid && in_ready;
    assign wr_done  = accept && !resync && in_last && wr_idx == LAST_IDX;
    // a group is malformed when in_last and the final index disagree
    assign wr_bad   = accept && !resync && (in_last != (wr_idx == LAST_IDX));

    always_ff @(posedge clk) begin
        if (accept && !resync) begin
            bank_x[wr_ptr][wr_idx] <= in_x;
            bank_y[wr_ptr][wr_idx] <= in_y;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= 1'b0;
            wr_idx    <= '0;
            resync    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= wr_bad;
            if (accept) begin
                if (resync) begin
                    resync <= !in_last;
                end else if (in_last || wr_idx == LAST_IDX) begin
                    wr_idx <= '0;
                    resync <= !in_last;
                    wr_ptr <= wr_ptr ^ wr_done;
                end else begin
                    wr_idx <= wr_idx + 1'b1;
                end
            end
        end
    end

    // loading and streaming never target the same bank, so both updates can land together
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            full <= '0;
        end else begin
            if (wr_done) full[wr_ptr] <= 1'b1;
            if (release_bank) full[rd_ptr] <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx     = state;
        start        = 1'b0;
        advance      = 1'b0;
        release_bank = 1'b0;
        capture      = 1'b0;
        case (state)
            IDLE: begin
                start    = full[rd_ptr];
                state_nx = full[rd_ptr] ? STREAM : IDLE;
            end
            STREAM: begin
                release_bank = cnt == LAST_IDX;
                advance      = cnt != LAST_IDX;
                state_nx     = cnt == LAST_IDX ? WAIT : STREAM;
            end
            WAIT: begin
                capture  = gf_valid;
                start    = gf_valid && full[rd_ptr];
                state_nx = !gf_valid ? WAIT : (full[rd_ptr] ? STREAM : IDLE);
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gf_reset   <= 1'b1;
            X          <= '0;
            Y          <= '0;
            cnt        <= '0;
            rd_ptr     <= 1'b0;
            tag        <= '0;
            res_valid  <= 1'b0;
            res_inside <= 1'b0;
            res_tag    <= '0;
        end else begin
            res_valid <= capture;
            if (start) begin
                gf_reset <= 1'b0;
                cnt      <= '0;
                X        <= bank_x[rd_ptr][0];
                Y        <= bank_y[rd_ptr][0];
            end else if (capture) begin
                gf_reset <= 1'b1;
            end
            if (advance) begin
                cnt <= cnt + 1'b1;
                X   <= bank_x[rd_ptr][cnt + 1'b1];
                Y   <= bank_y[rd_ptr][cnt + 1'b1];
            end
            if (release_bank) rd_ptr <= !rd_ptr;
            if (capture) begin
                res_inside <= gf_is_inside;
                res_tag    <= tag;
                tag        <= tag + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_geofence_feeder.sv
// tb_geofence_feeder: randomized bench with a queue-based reference model of the feeder,
// acting as both the host and the evaluator.
module tb_geofence_feeder;
    localparam int CW  = 10;
    localparam int PTS = 7;
    localparam int TW  = 8;
    localparam int PW  = 2 * CW;
    localparam int GW  = PW * PTS;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic in_valid = 1'b0, in_last = 1'b0, gf_valid = 1'b0, gf_is_inside = 1'b0;
    logic [CW-1:0] in_x = '0, in_y = '0;
    logic in_ready, gf_reset, res_valid, res_inside, frame_err;
    logic [CW-1:0] X, Y;
    logic [TW-1:0] res_tag;

    geofence_feeder #(.CW(CW), .PTS(PTS), .TW(TW)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .in_last(in_last), .gf_reset(gf_reset), .X(X), .Y(Y),
        .gf_valid(gf_valid), .gf_is_inside(gf_is_inside), .res_valid(res_valid),
        .res_inside(res_inside), .res_tag(res_tag), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic last;
    } beat_t;

    beat_t hq[$];
    logic [PW-1:0] cur[$];
    logic [GW-1:0] gq[$];
    int m_phase;
    bit m_rs, m_gfr, m_rv, m_ri, m_fe;
    logic [CW-1:0] m_x, m_y;
    logic [TW-1:0] m_tag, m_rt;
    int vectors = 0, errors = 0, n_ferr = 0, n_res = 0;
    logic [TW-1:0] last_tag;
    bit last_in, acc;
    int lx[PTS] = '{5, 0, 10, 12, 10, 0, 2};
    int ly[PTS] = '{5, 0, 0, 6, 10, 10, 8};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic mreset();
        m_phase = -1; m_rs = 0; m_gfr = 1; m_rv = 0; m_ri = 0; m_fe = 0;
        m_x = '0; m_y = '0; m_tag = '0; m_rt = '0;
        cur.delete(); gq.delete();
        n_ferr = 0; n_res = 0; last_tag = '1; last_in = 0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0; in_valid = 1'b0; gf_valid = 1'b0;
        hq.delete();
        #1;
        chk("rst_gf_reset", gf_reset, 1);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_x", X, 0);
        chk("rst_y", Y, 0);
        chk("rst_res_tag", res_tag, 0);
        chk("rst_frame_err", frame_err, 0);
        repeat (2) @(negedge clk);
        chk("rst_in_ready_hold", in_ready, 0);
        reset_n = 1'b1;
        mreset();
        #1;
        chk("post_rst_in_ready", in_ready, 1);
    endtask

    task automatic push_group(input int len);
        for (int i = 0; i < len; i++)
            hq.push_back({CW'($urandom), CW'($urandom), i == len - 1});
    endtask

    task automatic drive(input int gap, input int gvp);
        in_valid = hq.size() > 0 && int'($urandom_range(99)) >= gap;
        {in_x, in_y, in_last} = hq.size() > 0 ? hq[0] : '0;
        gf_valid = m_phase == 7 ? int'($urandom_range(99)) < gvp : $urandom_range(15) == 0;
        gf_is_inside = 1'($urandom_range(1));
    endtask

    // one clock: model the edge from the spec's rules, then compare after it
    task automatic cyc();
        bit rdy;
        logic [GW-1:0] g;
        rdy = gq.size() < 2;
        chk("in_ready", in_ready, rdy);
        acc = in_valid && rdy;
        m_rv = 0; m_fe = 0;
        if (m_phase == -1) begin
            if (gq.size() > 0) begin
                m_phase = 0; m_gfr = 0; {m_x, m_y} = gq[0][0 +: PW];
            end
        end else if (m_phase < 6) begin
            m_phase++;
            {m_x, m_y} = gq[0][m_phase * PW +: PW];
        end else if (m_phase == 6) begin
            m_phase = 7;
            void'(gq.pop_front());
        end else if (gf_valid) begin
            m_rv = 1; m_ri = gf_is_inside; m_rt = m_tag; m_tag++;
            if (gq.size() > 0) begin
                m_phase = 0; {m_x, m_y} = gq[0][0 +: PW];
            end else begin
                m_phase = -1; m_gfr = 1;
            end
        end
        if (acc) begin
            if (m_rs) begin
                if (in_last) m_rs = 0;
            end else begin
                cur.push_back({in_x, in_y});
                if (in_last) begin
                    if (cur.size() == PTS) begin
                        for (int k = 0; k < PTS; k++) g[k * PW +: PW] = cur[k];
                        gq.push_back(g);
                    end else m_fe = 1;
                    cur.delete();
                end else if (cur.size() == PTS) begin
                    m_fe = 1; m_rs = 1; cur.delete();
                end
            end
        end
        @(negedge clk);
        chk("gf_reset", gf_reset, m_gfr);
        chk("X", X, m_x);
        chk("Y", Y, m_y);
        chk("res_valid", res_valid, m_rv);
        chk("res_inside", res_inside, m_ri);
        chk("res_tag", res_tag, m_rt);
        chk("frame_err", frame_err, m_fe);
        n_ferr += int'(frame_err);
        if (res_valid) begin
            n_res++; last_tag = res_tag; last_in = res_inside;
        end
        if (acc) void'(hq.pop_front());
    endtask

    task automatic run(input int maxc, input int gap, input int gvp);
        int c = 0;
        while ((hq.size() > 0 || gq.size() > 0 || m_phase != -1) && c < maxc) begin
            drive(gap, gvp);
            cyc();
            c++;
        end
        if (c >= maxc) begin
            errors++;
            $display("FAIL run_timeout: got %0d cycles, required fewer than %0d", c, maxc);
        end
        in_valid = 1'b0; gf_valid = 1'b0;
    endtask

    initial begin
        mreset();
        @(negedge clk);
        do_reset();

        // single group with hand-computed stream contents
        for (int i = 0; i < PTS; i++) hq.push_back({CW'(lx[i]), CW'(ly[i]), i == PTS - 1});
        repeat (PTS) begin drive(0, 0); cyc(); end
        for (int k = 0; k < PTS; k++) begin
            drive(0, 0); cyc();
            chk("lit_gf_reset", gf_reset, 0);
            chk("lit_x", X, lx[k]);
            chk("lit_y", Y, ly[k]);
        end
        drive(0, 0); cyc();
        drive(0, 100); gf_is_inside = 1'b1; cyc();
        chk("lit_res_valid", res_valid, 1);
        chk("lit_res_inside", res_inside, 1);
        chk("lit_res_tag", res_tag, 0);
        run(50, 0, 100);

        // back-to-back groups
        do_reset();
        repeat (3) push_group(PTS);
        run(400, 0, 100);
        chk("b2b_results", n_res, 3);
        chk("b2b_last_tag", last_tag, 2);

        // early in_last then a good group
        do_reset();
        push_group(4); push_group(PTS);
        run(400, 0, 100);
        chk("early_last_ferr", n_ferr, 1);
        chk("early_last_results", n_res, 1);
        chk("early_last_tag", last_tag, 0);

        // missing in_last: nine beats, then a good group
        do_reset();
        push_group(9); push_group(PTS);
        run(400, 0, 100);
        chk("resync_ferr", n_ferr, 1);
        chk("resync_results", n_res, 1);
        chk("resync_tag", last_tag, 0);

        // reset at stream cycle 3
        do_reset();
        push_group(PTS);
        for (int c = 0; c < 40 && m_phase != 3; c++) begin drive(0, 0); cyc(); end
        chk("midstream_reached", m_phase == 3, 1);
        do_reset();
        push_group(PTS);
        run(400, 0, 100);
        chk("after_reset_results", n_res, 1);
        chk("after_reset_tag", last_tag, 0);

        // random framing, gaps and evaluator latency
        do_reset();
        for (int i = 0; i < 40; i++) push_group($urandom_range(9) < 7 ? PTS : int'($urandom_range(9, 1)));
        run(20000, 30, 40);

        // tag wrap
        do_reset();
        repeat (257) push_group(PTS);
        run(8000, 0, 100);
        chk("wrap_results", n_res, 257);
        chk("wrap_last_tag", last_tag, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
